// File: rtl/dfm_data_mem_pkg.sv
// Shared definitions for the CPU data-side memory block.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package pkg_dfm_defs;

  // addr[31:28] value that selects the data region by default
  localparam logic [3:0] DFM_BASE_NIBBLE_DEF = 4'b0001;

  // width of the saturating write-fault counter
  localparam int DFM_FAULT_CNT_W = 8;

  typedef enum logic {DFM_CLEAR, DFM_READY} dfm_state_t;

  // even parity: the stored bit makes the XOR of all 33 bits zero
  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dfm_data_mem_sram_core.sv
// Single-port synchronous RAM, read-first, no reset on the array.
// Latency: 1 cycle from rd_en/addr to rd_data; rd_data holds when rd_en is low.
// Backpressure: none, one access per cycle.
module dfm_sram_core #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // array write; the read register below samples the pre-write word
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  // output register: cleared by reset, updated only on an enabled read
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[addr];
  end

endmodule

// File: rtl/dfm_data_mem.sv
// Data region decode, post-reset zero-fill, RAM and write-fault capture; optional parity via DFM_PARITY_EN.
// Latency: read data 1 cycle after the address edge; writes commit at the sampling edge.
// Backpressure: none; accesses during zero-fill (dfm_ready=0) are dropped.
module dfm_data_mem
  import pkg_dfm_defs::*;
#(
  parameter int         DEPTH       = 1024,
  parameter logic [3:0] BASE_NIBBLE = DFM_BASE_NIBBLE_DEF
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [31:0]                dfm_req_addr,
  input  logic                       dfm_wr_en,
  input  logic [31:0]                dfm_wr_data,
  output logic [31:0]                dfm_rd_data,
  output logic                       dfm_ready,
  output logic                       dfm_wr_fault,
  output logic [31:0]                dfm_fault_addr,
  output logic [DFM_FAULT_CNT_W-1:0] dfm_fault_cnt,
  output logic                       dfm_par_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [26:0] DEPTH_L = 27'(DEPTH);
`ifdef DFM_PARITY_EN
  localparam int RAM_W = 33;
`else
  localparam int RAM_W = 32;
`endif

  dfm_state_t        state, state_nxt;
  logic [AW-1:0]     clr_ptr;
  logic              hit;
  logic [AW-1:0]     idx;
  logic              ram_rd, ram_wr;
  logic [AW-1:0]     ram_addr;
  logic [RAM_W-1:0]  ram_wdata, wr_word, ram_q;

  // word index beyond DEPTH is a miss even inside the right nibble
  assign hit = (dfm_req_addr[31:28] == BASE_NIBBLE) &&
               ({1'b0, dfm_req_addr[27:2]} < DEPTH_L);
  assign idx = dfm_req_addr[AW+1:2];

`ifdef DFM_PARITY_EN
  assign wr_word = {even_par(dfm_wr_data), dfm_wr_data};
`else
  assign wr_word = dfm_wr_data;
`endif

  // state register and zero-fill pointer
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= DFM_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == DFM_CLEAR) clr_ptr <= clr_ptr + AW'(1);
    end
  end

  // next state and RAM port steering: zero-fill owns the port until READY
  always_comb begin
    state_nxt = state;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = idx;
    ram_wdata = wr_word;
    case (state)
      DFM_CLEAR: begin
        ram_wr    = 1'b1;
        ram_addr  = clr_ptr;
        ram_wdata = '0;
        if (clr_ptr == AW'(DEPTH - 1)) state_nxt = DFM_READY;
      end
      DFM_READY: begin
        ram_rd = hit;
        ram_wr = hit && dfm_wr_en;
      end
    endcase
  end

  assign dfm_ready = (state == DFM_READY);

  dfm_sram_core #(.WIDTH(RAM_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .rd_en   (ram_rd),
    .wr_en   (ram_wr),
    .addr    (ram_addr),
    .wr_data (ram_wdata),
    .rd_data (ram_q)
  );

  assign dfm_rd_data = ram_q[31:0];

  // sticky fault flag, first-fault address and saturating count for dropped writes
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dfm_wr_fault   <= 1'b0;
      dfm_fault_addr <= '0;
      dfm_fault_cnt  <= '0;
    end else if ((state == DFM_READY) && !hit && dfm_wr_en) begin
      dfm_wr_fault <= 1'b1;
      if (!dfm_wr_fault)      dfm_fault_addr <= dfm_req_addr;
      if (dfm_fault_cnt != '1) dfm_fault_cnt <= dfm_fault_cnt + 1'b1;
    end
  end

`ifdef DFM_PARITY_EN
  logic rd_chk;

  // marks the cycle in which ram_q carries a fresh hit read worth checking
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) rd_chk <= 1'b0;
    else            rd_chk <= (state == DFM_READY) && hit;
  end

  assign dfm_par_err = rd_chk & (^ram_q);
`else
  assign dfm_par_err = 1'b0;
`endif

endmodule
